// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared encodings and helpers for burst_memory: burst-length
//                and transfer-size codes, FSM state enum, burst length decode,
//                big-endian byte-lane mask and write-data lane placement.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

   typedef enum logic [1:0] {
      ACC_1  = 2'b00,
      ACC_4  = 2'b01,
      ACC_8  = 2'b10,
      ACC_16 = 2'b11
   } acc_e;

   typedef enum logic [1:0] {
      XFER_WORD  = 2'b00,
      XFER_HALF  = 2'b01,
      XFER_BYTE  = 2'b10,
      XFER_WORD2 = 2'b11
   } xfer_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD_BURST = 2'd1,
      ST_WR_BURST = 2'd2
   } state_e;

   // Number of word beats encoded by an access_size code.
   function automatic logic [4:0] burst_len(input logic [1:0] acc);
      logic [4:0] len;
      case (acc)
         ACC_4:   len = 5'd4;
         ACC_8:   len = 5'd8;
         ACC_16:  len = 5'd16;
         default: len = 5'd1;
      endcase
      return len;
   endfunction

   // Bit 3 is the lane carrying data[31:24], i.e. the byte at word offset 0.
   function automatic logic [3:0] lane_mask(input logic [1:0] xfer, input logic [1:0] off);
      logic [3:0] m;
      case (xfer)
         XFER_HALF: m = off[1] ? 4'b0011 : 4'b1100;
         XFER_BYTE: m = 4'b1000 >> off;
         default:   m = 4'b1111;
      endcase
      return m;
   endfunction

   // Replicate right-justified sub-word data across all lanes; the lane mask
   // then picks the ones actually written.
   function automatic logic [31:0] place_wdata(input logic [1:0] xfer, input logic [31:0] d);
      logic [31:0] w;
      case (xfer)
         XFER_HALF: w = {2{d[15:0]}};
         XFER_BYTE: w = {4{d[7:0]}};
         default:   w = d;
      endcase
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_byte_array
//  Description : Four byte-lane storage arrays with per-lane write enables
//                and one shared synchronous read port. Storage is never reset.
//  Ports       : clock  - rising-edge clock
//                we     - per-lane write enable (lane i = wdata[8i+7:8i])
//                addr   - word index for read or write
//                wdata  - write data
//                re     - read enable; rdata holds its value when low
//                rdata  - registered read data
//  Revision    : 1.0  initial release
// ============================================================================
module mem_byte_array #(
   parameter int unsigned DEPTH_WORDS = 262144,
   parameter int unsigned ADDR_W      = 18
) (
   input  logic              clock,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic              re,
   output logic [31:0]       rdata
);

   for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] rd_q;

      always_ff @(posedge clock) begin
         if (we[i]) begin
            lane_mem[addr] <= wdata[8*i +: 8];
         end
         if (re) begin
            rd_q <= lane_mem[addr];
         end
      end

      assign rdata[8*i +: 8] = rd_q;
   end

endmodule
`default_nettype wire

// File: rtl/burst_memory.sv
`default_nettype none
// ============================================================================
//  Module      : burst_memory
//  Description : Byte-addressed big-endian unified memory with byte/half/word
//                single accesses, 4/8/16-word read and write bursts,
//                write-back bypass, branch flush, address-error reporting.
//  Ports       : clock, reset_n      - clock, async active-low reset
//                address, data_in    - first-beat byte address, write data
//                access_size         - burst length code (1/4/8/16 words)
//                xfer_size           - word/half/byte for single accesses
//                load_unsigned       - zero- (1) or sign- (0) extend loads
//                rw, enable          - 1=read/0=write, request strobe
//                wm_bypass, do_wm_bypass - forwarded store data and select
//                do_branch           - flush read data, abort read burst
//                busy                - burst in progress
//                data_out, data_valid- read data and its one-cycle strobe
//                addr_error          - one-cycle pulse on rejected request
//  Revision    : 1.0  initial release
// ============================================================================
module burst_memory
   import mem_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 1048576,
   parameter logic [31:0] BASE_ADDR = 32'h8002_0000,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] address,
   input  logic [31:0] data_in,
   input  logic [1:0]  access_size,
   input  logic [1:0]  xfer_size,
   input  logic        load_unsigned,
   input  logic        rw,
   input  logic        enable,
   input  logic [31:0] wm_bypass,
   input  logic        do_wm_bypass,
   input  logic        do_branch,
   output logic        busy,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        addr_error
);

   localparam int unsigned DEPTH_WORDS = MEM_DEPTH / 4;
   localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);

   state_e           state_q, state_d;
   logic [4:0]       beat_q, beat_d;
   logic [4:0]       len_q, len_d;
   logic [IDX_W-1:0] addr_q, addr_d;     // word index of the next burst beat
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             zero_q, zero_d;     // data_out forced to 0 (reset/flush)
   logic             uns_q, uns_d;
   logic [1:0]       rd_xfer_q, rd_xfer_d;
   logic [1:0]       rd_off_q, rd_off_d;

   // Request decode
   logic [31:0] w_req_offset;
   logic [4:0]  w_req_len;
   logic [1:0]  w_req_xfer;
   logic [6:0]  w_req_bytes;
   logic [33:0] w_req_end;
   logic        w_req_aligned;
   logic        w_req_ok;

   // Storage port
   logic [3:0]       w_mem_we;
   logic             w_mem_re;
   logic [IDX_W-1:0] w_mem_idx;
   logic [31:0]      w_mem_wdata;
   logic [31:0]      w_mem_rdata;
   logic [31:0]      w_wsrc;
   logic             w_last;

   always_comb begin
      w_req_offset = address - BASE_ADDR;
      w_req_len    = burst_len(access_size);
      w_req_xfer   = (access_size != ACC_1) ? XFER_WORD : xfer_size;
      case (w_req_xfer)
         XFER_HALF: begin
            w_req_bytes   = 7'd2;
            w_req_aligned = ~address[0];
         end
         XFER_BYTE: begin
            w_req_bytes   = 7'd1;
            w_req_aligned = 1'b1;
         end
         default: begin
            w_req_bytes   = {w_req_len, 2'b00};
            w_req_aligned = (address[1:0] == 2'b00);
         end
      endcase
      // Wide sum so addresses below BASE_ADDR (huge offsets) fail the range test.
      w_req_end = {2'b00, w_req_offset} + {27'd0, w_req_bytes};
      w_req_ok  = w_req_aligned
                  && (w_req_end <= 34'(MEM_DEPTH))
                  && (32'(w_req_len) <= MAX_BURST);
   end

   assign w_wsrc = do_wm_bypass ? wm_bypass : data_in;
   assign w_last = (beat_q == (len_q - 5'd1));

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      len_d       = len_q;
      addr_d      = addr_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      zero_d      = zero_q;
      uns_d       = uns_q;
      rd_xfer_d   = rd_xfer_q;
      rd_off_d    = rd_off_q;
      w_mem_we    = 4'b0000;
      w_mem_re    = 1'b0;
      w_mem_idx   = addr_q;
      w_mem_wdata = w_wsrc;

      case (state_q)
         ST_IDLE: begin
            if (do_branch && rw) begin
               // Flush wins over a read accept at the same edge.
               zero_d = 1'b1;
            end else if (enable) begin
               if (!w_req_ok) begin
                  err_d = 1'b1;
               end else begin
                  w_mem_idx = w_req_offset[IDX_W+1:2];
                  if (rw) begin
                     w_mem_re  = 1'b1;
                     valid_d   = 1'b1;
                     zero_d    = 1'b0;
                     uns_d     = load_unsigned;
                     rd_xfer_d = w_req_xfer;
                     rd_off_d  = address[1:0];
                  end else begin
                     w_mem_we    = lane_mask(w_req_xfer, address[1:0]);
                     w_mem_wdata = place_wdata(w_req_xfer, w_wsrc);
                  end
                  if (w_req_len != 5'd1) begin
                     state_d = rw ? ST_RD_BURST : ST_WR_BURST;
                     beat_d  = 5'd1;
                     len_d   = w_req_len;
                     addr_d  = w_req_offset[IDX_W+1:2] + 1'b1;
                  end
               end
            end
         end

         ST_RD_BURST: begin
            if (do_branch) begin
               zero_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               w_mem_re  = 1'b1;
               valid_d   = 1'b1;
               zero_d    = 1'b0;
               rd_xfer_d = XFER_WORD;
               rd_off_d  = 2'b00;
               if (w_last) begin
                  state_d = ST_IDLE;
               end else begin
                  beat_d = beat_q + 5'd1;
                  addr_d = addr_q + 1'b1;
               end
            end
         end

         ST_WR_BURST: begin
            w_mem_we = 4'b1111;
            if (w_last) begin
               state_d = ST_IDLE;
            end else begin
               beat_d = beat_q + 5'd1;
               addr_d = addr_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         beat_q    <= 5'd0;
         len_q     <= 5'd0;
         addr_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         zero_q    <= 1'b1;
         uns_q     <= 1'b0;
         rd_xfer_q <= XFER_WORD;
         rd_off_q  <= 2'b00;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         len_q     <= len_d;
         addr_q    <= addr_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         zero_q    <= zero_d;
         uns_q     <= uns_d;
         rd_xfer_q <= rd_xfer_d;
         rd_off_q  <= rd_off_d;
      end
   end

   mem_byte_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (IDX_W)
   ) u_array (
      .clock (clock),
      .we    (w_mem_we),
      .addr  (w_mem_idx),
      .wdata (w_mem_wdata),
      .re    (w_mem_re),
      .rdata (w_mem_rdata)
   );

   // Extraction and extension act on the registered array output and the
   // registered beat attributes, so data_out only changes at clock edges.
   logic [15:0] w_rd_half;
   logic [7:0]  w_rd_byte;
   logic [31:0] w_rd_ext;

   always_comb begin
      w_rd_half = rd_off_q[1] ? w_mem_rdata[15:0] : w_mem_rdata[31:16];
      case (rd_off_q)
         2'd0:    w_rd_byte = w_mem_rdata[31:24];
         2'd1:    w_rd_byte = w_mem_rdata[23:16];
         2'd2:    w_rd_byte = w_mem_rdata[15:8];
         default: w_rd_byte = w_mem_rdata[7:0];
      endcase
      case (rd_xfer_q)
         XFER_HALF: w_rd_ext = uns_q ? {16'd0, w_rd_half} : {{16{w_rd_half[15]}}, w_rd_half};
         XFER_BYTE: w_rd_ext = uns_q ? {24'd0, w_rd_byte} : {{24{w_rd_byte[7]}}, w_rd_byte};
         default:   w_rd_ext = w_mem_rdata;
      endcase
   end

   assign data_out   = zero_q ? 32'd0 : w_rd_ext;
   assign data_valid = valid_q;
   assign addr_error = err_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/burst_memory.md
# burst_memory

Byte-addressed, big-endian unified memory for the MIPS pipeline. It generalises the single-word instruction/data memory with byte/halfword/word transfers, sign or zero extension on loads, and multi-beat read and write bursts for instruction-fetch and cache refill. It keeps the write-back bypass and branch-flush behaviour, and adds a registered valid strobe and an address-error flag. It sits between fetch/memory stages and the backing store.

## Interface
- MEM_DEPTH, 1048576, storage size in bytes
- BASE_ADDR, 32'h80020000, byte address mapped to storage offset 0
- MAX_BURST, 16, longest burst in words; must be 4, 8 or 16
---
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  32  byte address of first beat
- data_in  in  32  write data; sub-word data is right-justified
- access_size  in  2  burst length: 00=1, 01=4, 10=8, 11=16 words; codes above MAX_BURST are errors
- xfer_size  in  2  00=word, 01=half, 10=byte, 11=word; honoured only when access_size=00
- load_unsigned  in  1  1=zero-extend sub-word loads, 0=sign-extend
- rw  in  1  1=read, 0=write
- enable  in  1  request strobe, sampled only in IDLE
- wm_bypass  in  32  write-back forwarded store data
- do_wm_bypass  in  1  select wm_bypass instead of data_in for the current write beat
- do_branch  in  1  flush: squash read data, abort read burst
- busy  out  1  burst in progress; new requests ignored
- data_out  out  32  registered read data
- data_valid  out  1  data_out holds a new beat this cycle
- addr_error  out  1  one-cycle pulse: request rejected

## Operation
- States: IDLE, RD_BURST, WR_BURST.
- Accept: IDLE and enable at an edge. The request is checked first.
- Check: offset = address − BASE_ADDR; offset + 4·L (or the sub-word size) ≤ MEM_DEPTH.
- Check: bursts and words need address[1:0]=0; halfwords need address[0]=0.
- Failed check: addr_error=1 for one cycle; no storage access; stay in IDLE.
- Beat 0 executes at the accept edge. If L>1, the FSM enters RD_BURST or WR_BURST with a beat counter and an address register that steps +4 per beat. There is no wrap-around.
- Beat k executes at accept edge + k. After beat L−1 the FSM returns to IDLE.
- Writes are big-endian: byte at offset+0 = data[31:24]. Sub-word writes touch only the addressed bytes, taken from data[15:0] or data[7:0].
- Write source per beat is wm_bypass if do_wm_bypass, else data_in, sampled at that beat's edge.
- Reads: data_out is registered at the beat edge; data_valid=1 for that following cycle, else 0.
- Sub-word reads are right-justified and extended per load_unsigned.
- do_branch with rw=1 at an edge: data_out←0, data_valid←0, and a read burst aborts to IDLE.
- do_branch during a write burst has no effect.
- do_branch at the same edge as a read accept: the branch wins and no access occurs.
- reset_n low: FSM→IDLE; busy, data_out, data_valid and addr_error →0. Storage is not cleared. Beats already written persist; the remainder of the burst is dropped.

## Timing
- Single access: read data valid one cycle after the accept edge; the write is visible to a read issued at the next edge.
- busy rises after the accept edge for L>1 and falls after the beat L−1 edge. It stays 0 for single accesses.
- enable, address, access_size and rw are ignored while busy. data_in, do_wm_bypass and do_branch are sampled every beat.
- Back-to-back requests: a new accept is legal at the edge after busy falls. No idle cycle is needed.

## Structure
- Package mem_pkg holds:
  - access_size and xfer_size encodings
  - the FSM state enum
  - the burst length function len(access_size)
  - the big-endian byte-lane mask function
- Sub-module mem_byte_array: four byte-lane arrays of MEM_DEPTH/4 entries, per-lane write enable, one synchronous read port.
- The top level holds the FSM, counter, address checking, extension and bypass mux.

## Test plan
- Word write 32'hDEADBEEF @80020000, then read -> next cycle data_out=DEADBEEF, data_valid=1; byte read @80020001 unsigned -> 000000AD; signed -> FFFFFFAD.
- Half write 16'h1234 @80020002, then word read @80020000 -> DEAD1234; half read @80020001 -> addr_error pulse, no data_valid.
- 4-word write burst @80020100 with data 1,2,3,4 -> busy high 3 cycles; 4-word read burst -> data_valid 4 consecutive cycles returning 1,2,3,4 in order.
- 8-word read burst with do_branch on beat 3 -> data_out=0, busy falls, no further data_valid; next request is accepted immediately.
- Write with do_wm_bypass=1, wm_bypass=CAFEF00D, data_in=0 -> readback CAFEF00D; burst at MEM_DEPTH−8 with L=4 -> addr_error, storage unchanged.
- reset_n pulled low mid 16-word write burst -> busy=0 asynchronously; beats before reset read back, later words keep their old contents.
